// File: rtl/usng_pkg.sv
// Shared definitions for the unipolar stochastic stream-pair generator.
package usng_pkg;

  localparam int unsigned BITWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/usng_seqgen.sv
// Sequence counter for the stream pair; also exposes the bit-reversed count
// so the two streams stay decorrelated without any LFSR bias.
module usng_seqgen
  import usng_pkg::*;
#(
  parameter int unsigned BITWIDTH = BITWIDTH_DEF
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iClr,
  input  logic                iEn,
  output logic [BITWIDTH-1:0] oCnt,
  output logic [BITWIDTH-1:0] oCntRev_c
);

  always_ff @(posedge iClk) begin : cnt_reg
    if (iRst || iClr) begin
      oCnt <= '0;
    end else if (iEn) begin
      oCnt <= oCnt + BITWIDTH'(1);
    end
  end

  always_comb begin : cnt_rev
    oCntRev_c = '0;
    for (int unsigned i = 0; i < BITWIDTH; i++) begin
      oCntRev_c[i] = oCnt[BITWIDTH-1-i];
    end
  end

endmodule

// File: rtl/usng_pair.sv
// Generates a pair of exact-count unipolar stochastic streams (A and B) that
// feed a scaled adder; A compares against cnt, B against reversed cnt.
module usng_pair
  import usng_pkg::*;
#(
  parameter int unsigned BITWIDTH = BITWIDTH_DEF
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic [BITWIDTH-1:0] iValA,
  input  logic [BITWIDTH-1:0] iValB,
  output logic                oA,
  output logic                oB,
  output logic                oValid,
  output logic                oBusy,
  output logic                oDone
);

  state_t                state;
  state_t                stateNxt;
  logic [BITWIDTH-1:0]   valALat;
  logic [BITWIDTH-1:0]   valBLat;
  logic [BITWIDTH-1:0]   cnt;
  logic [BITWIDTH-1:0]   cntRev;
  logic                  isLast;
  logic                  latch;
  logic                  cntClr;
  logic                  cntEn;
  logic                  aNxt;
  logic                  bNxt;
  logic                  validNxt;
  logic                  busyNxt;
  logic                  doneNxt;

  usng_seqgen #(.BITWIDTH(BITWIDTH)) u_seqgen (
    .iClk      (iClk),
    .iRst      (iRst),
    .iClr      (cntClr),
    .iEn       (cntEn),
    .oCnt      (cnt),
    .oCntRev_c (cntRev)
  );

  assign isLast = (cnt == {BITWIDTH{1'b1}});

  always_ff @(posedge iClk) begin : state_reg
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Abort only matters in IDLE (blocks a start) and RUN; DONE always completes.
  always_comb begin : next_state
    stateNxt = state;
    case (state)
      IDLE:    if (iStart && !iAbort) stateNxt = RUN;
      RUN: begin
        if (iAbort)      stateNxt = IDLE;
        else if (isLast) stateNxt = DONE;
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin : out_logic
    latch    = 1'b0;
    cntClr   = 1'b0;
    cntEn    = 1'b0;
    aNxt     = 1'b0;
    bNxt     = 1'b0;
    validNxt = 1'b0;
    doneNxt  = 1'b0;
    case (state)
      IDLE: begin
        if (iStart && !iAbort) begin
          latch  = 1'b1;
          cntClr = 1'b1;
        end
      end
      RUN: begin
        if (!iAbort) begin
          aNxt     = (valALat > cnt);
          bNxt     = (valBLat > cntRev);
          validNxt = 1'b1;
          cntEn    = 1'b1;
        end
      end
      DONE:    doneNxt = 1'b1;
      default: ;
    endcase
    busyNxt = (stateNxt != IDLE);
  end

  always_ff @(posedge iClk) begin : out_reg
    if (iRst) begin
      valALat <= '0;
      valBLat <= '0;
      oA      <= 1'b0;
      oB      <= 1'b0;
      oValid  <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      if (latch) begin
        valALat <= iValA;
        valBLat <= iValB;
      end
      oA     <= aNxt;
      oB     <= bNxt;
      oValid <= validNxt;
      oBusy  <= busyNxt;
      oDone  <= doneNxt;
    end
  end

endmodule

// File: tb/tb_usng_pair.sv
// Scoreboard bench for usng_pair: stimulus pushes expected stream bits and
// per-pair ones counts; a negedge monitor pops and compares.
module tb_usng_pair;

  localparam int unsigned BW  = 8;
  localparam int          LEN = 1 << BW;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic          iAbort;
  logic [BW-1:0] iValA;
  logic [BW-1:0] iValB;
  logic          oA;
  logic          oB;
  logic          oValid;
  logic          oBusy;
  logic          oDone;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int onesA;
    int onesB;
  } done_t;

  logic [1:0] expQ[$];
  done_t      doneQ[$];

  always #5 iClk = ~iClk;

  usng_pair #(.BITWIDTH(BW)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iAbort (iAbort),
    .iValA  (iValA),
    .iValB  (iValB),
    .oA     (oA),
    .oB     (oB),
    .oValid (oValid),
    .oBusy  (oBusy),
    .oDone  (oDone)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-reversal by repeated division, independent of any bit slicing.
  function automatic int rev_model(input int k);
    int r = 0;
    int x = k;
    for (int i = 0; i < int'(BW); i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Stream k of a pair is 1 while the sequence index is below the operand.
  task automatic push_pair(input int a, input int b);
    done_t d;
    logic  ea;
    logic  eb;
    for (int k = 0; k < LEN; k++) begin
      ea = (k < a);
      eb = (rev_model(k) < b);
      expQ.push_back({ea, eb});
    end
    d.onesA = a;
    d.onesB = b;
    doneQ.push_back(d);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic flush();
    expQ.delete();
    doneQ.delete();
  endtask

  task automatic start_pair(input int a, input int b);
    iValA  = BW'(a);
    iValB  = BW'(b);
    iStart = 1'b1;
    iAbort = 1'b0;
    tick();
    iStart = 1'b0;
    push_pair(a, b);
    chk("busy_after_accept", int'(oBusy), 1);
    chk("valid_after_accept", int'(oValid), 0);
  endtask

  // mode 0: plain; 1: operand noise plus a restart attempt; 2: abort during DONE
  task automatic run_to_done(input int mode);
    int n     = 0;
    int first = 0;
    bit done  = 1'b0;
    while (!done && n < 400) begin
      if (mode == 1) begin
        iValA  = BW'($urandom);
        iValB  = BW'($urandom);
        iStart = (n == 4);
      end
      if (mode == 2 && n == LEN) iAbort = 1'b1;
      tick();
      n++;
      if (oValid && first == 0) first = n;
      if (oDone) done = 1'b1;
    end
    iStart = 1'b0;
    iAbort = 1'b0;
    chk("first_valid_edge", first, 1);
    chk("done_edge", n, LEN + 1);
    chk("busy_at_done", int'(oBusy), 0);
  endtask

  int  aOnes  = 0;
  int  bOnes  = 0;
  int  nValid = 0;
  bit  inPair = 1'b0;

  always @(negedge iClk) begin : monitor
    logic [1:0] e;
    done_t      d;
    if (!iRst) begin
      if (oValid) begin
        if (!inPair) begin
          aOnes  = 0;
          bOnes  = 0;
          nValid = 0;
          inPair = 1'b1;
        end
        chk("valid_expected", int'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          chk("stream_bits", int'({oA, oB}), int'(e));
        end
        aOnes += int'(oA);
        bOnes += int'(oB);
        nValid++;
      end else begin
        inPair = 1'b0;
        chk("idle_bits", int'({oA, oB}), 0);
      end
      if (oDone) begin
        chk("done_valid_low", int'(oValid), 0);
        chk("done_expected", int'(doneQ.size() != 0), 1);
        if (doneQ.size() != 0) begin
          d = doneQ.pop_front();
          chk("ones_a", aOnes, d.onesA);
          chk("ones_b", bOnes, d.onesB);
          chk("valid_len", nValid, LEN);
        end
      end
    end
  end

  initial begin : stim
    int a;
    int b;
    iRst   = 1'b1;
    iStart = 1'b0;
    iAbort = 1'b0;
    iValA  = '0;
    iValB  = '0;
    repeat (3) tick();
    chk("rst_a", int'(oA), 0);
    chk("rst_b", int'(oB), 0);
    chk("rst_valid", int'(oValid), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_done", int'(oDone), 0);
    iRst = 1'b0;
    tick();

    start_pair(8'h40, 8'hC0);
    run_to_done(0);
    tick();
    start_pair(8'h00, 8'hFF);
    run_to_done(0);
    start_pair(8'h37, 8'h80);
    run_to_done(0);

    // second start mid-run must not relatch or restart
    start_pair(8'h21, 8'h9E);
    run_to_done(1);

    start_pair(8'h5A, 8'h33);
    repeat (10) tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    flush();
    chk("abort_valid", int'(oValid), 0);
    chk("abort_busy", int'(oBusy), 0);
    chk("abort_done", int'(oDone), 0);
    repeat (5) tick();
    start_pair(8'h70, 8'h11);
    run_to_done(0);

    // start and abort together in IDLE: nothing starts
    iValA  = 8'hAA;
    iValB  = 8'h55;
    iStart = 1'b1;
    iAbort = 1'b1;
    tick();
    iStart = 1'b0;
    iAbort = 1'b0;
    chk("idle_abort_busy", int'(oBusy), 0);
    tick();
    chk("idle_abort_valid", int'(oValid), 0);
    chk("idle_abort_busy2", int'(oBusy), 0);

    start_pair(8'hFF, 8'h01);
    run_to_done(2);

    start_pair(8'h9C, 8'h27);
    repeat (100) tick();
    iRst = 1'b1;
    tick();
    chk("midrst_a", int'(oA), 0);
    chk("midrst_b", int'(oB), 0);
    chk("midrst_valid", int'(oValid), 0);
    chk("midrst_busy", int'(oBusy), 0);
    chk("midrst_done", int'(oDone), 0);
    iRst = 1'b0;
    flush();
    tick();
    start_pair(8'h9C, 8'h27);
    run_to_done(0);

    repeat (4) begin
      a = int'($urandom_range(0, LEN - 1));
      b = int'($urandom_range(0, LEN - 1));
      start_pair(a, b);
      run_to_done(0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("expq_drained", expQ.size(), 0);
    chk("doneq_drained", doneQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
